// File: rtl/register_rw_pkg.sv
// Shared definitions for the register bank: lane arithmetic, flattened-vector
// offsets and the error-cause encoding used by the bank's err logic.
package register_rw_pkg;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_LOCK  = 2'b10;

  function automatic int lane_count(input int width);
    return width / 8;
  endfunction

  // LSB of register idx inside the flattened DEPTH*WIDTH vectors.
  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/register_rw_cell.sv
// One WIDTH-bit register with byte strobes, write lock, per-bit W1C mask and
// hardware set inputs. A hardware set beats a same-cycle W1C clear.
module register_rw_cell
  import register_rw_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] W1C_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [lane_count(WIDTH)-1:0] sel,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         lock,
  input  logic [WIDTH-1:0]             hw_set,
  output logic [WIDTH-1:0]             q
);

  localparam int LANES = lane_count(WIDTH);

  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] rw_upd;
  logic [WIDTH-1:0] w1c_clr;
  logic [WIDTH-1:0] q_next;

  for (genvar b = 0; b < LANES; b++) begin : g_lane
    assign lane_mask[b*8 +: 8] = {8{wr & sel[b]}};
  end

  always_comb begin
    rw_upd  = lane_mask & ~W1C_MASK & {WIDTH{~lock}};
    w1c_clr = lane_mask & W1C_MASK & data_in;
    q_next  = (((q & ~rw_upd) | (data_in & rw_upd)) & ~w1c_clr) | (hw_set & W1C_MASK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RESET_VAL;
    else      q <= q_next;
  end

endmodule

// File: rtl/register_rw_bank.sv
// Bank of DEPTH registers: address decode, registered read port and one-cycle
// err pulse for out-of-range accesses and locked writes to RW lanes.
module register_rw_bank
  import register_rw_pkg::*;
#(
  parameter int                     WIDTH     = 32,
  parameter int                     DEPTH     = 4,
  parameter int                     ADDR_W    = 2,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VAL = '0,
  parameter logic [DEPTH*WIDTH-1:0] W1C_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wren,
  input  logic                         rden,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [lane_count(WIDTH)-1:0] sel,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         lock,
  input  logic [DEPTH*WIDTH-1:0]       hw_set,
  output logic [WIDTH-1:0]             data_out,
  output logic                         rd_valid,
  output logic                         err,
  output logic [DEPTH*WIDTH-1:0]       regs_q
);

  localparam int              LANES   = lane_count(WIDTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic             in_range;
  logic [WIDTH-1:0] rd_mux;
  logic [LANES-1:0] rw_sel;
  logic [1:0]       err_cause;

  assign in_range = {1'b0, addr} < DEPTH_A;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    localparam int LSB = reg_lsb(i, WIDTH);
    register_rw_cell #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL[LSB +: WIDTH]),
      .W1C_MASK (W1C_MASK[LSB +: WIDTH])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .wr     (wren && in_range && (addr == ADDR_W'(i))),
      .sel    (sel),
      .data_in(data_in),
      .lock   (lock),
      .hw_set (hw_set[LSB +: WIDTH]),
      .q      (regs_q[LSB +: WIDTH])
    );
  end

  // rw_sel marks lanes of the addressed register holding at least one RW bit;
  // a locked write touching such a lane is flagged even though W1C bits update.
  always_comb begin
    rd_mux = '0;
    rw_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_mux = regs_q[i*WIDTH +: WIDTH];
        for (int b = 0; b < LANES; b++) rw_sel[b] = ~&W1C_MASK[i*WIDTH + b*8 +: 8];
      end
    end
    err_cause = ERR_NONE;
    if ((wren || rden) && !in_range)                  err_cause = err_cause | ERR_RANGE;
    if (wren && in_range && lock && |(sel & rw_sel))  err_cause = err_cause | ERR_LOCK;
  end

  // Read port: rden sampled at edge N yields rd_valid high for exactly the
  // cycle after N with data_out carrying the pre-write value; data_out holds
  // until the next read. err is aligned with rd_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rden;
      err      <= (err_cause != ERR_NONE);
      if (rden) data_out <= in_range ? rd_mux : '0;
    end
  end

endmodule

// File: doc/register_rw_bank.md
Name: register_rw_bank

Overview:
- Parametrised successor to the single 32-bit write-enabled register: a bank of DEPTH registers, each WIDTH bits wide, with byte-lane write strobes and a registered read port.
- Adds three features: per-bit write-1-to-clear (W1C) fields with hardware set inputs, a global write lock, and error signalling.
- Sits between the Wishbone slave decoder and the HyperRAM controller core, holding configuration, timing and status registers.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 4, number of registers; range 1..256.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.
- RESET_VAL, {DEPTH*WIDTH{1'b0}}, flattened reset values; register i occupies bits [i*WIDTH +: WIDTH].
- W1C_MASK, {DEPTH*WIDTH{1'b0}}, flattened per-bit mask; 1 = W1C/status bit, 0 = plain RW bit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wren  in  1  write request, single cycle.
- rden  in  1  read request, single cycle.
- addr  in  ADDR_W  register index for read or write.
- sel  in  WIDTH/8  byte-lane write strobes.
- data_in  in  WIDTH  write data.
- lock  in  1  when high, RW bits are write-protected.
- hw_set  in  DEPTH*WIDTH  per-bit hardware set pulses; effective on W1C bits only.
- data_out  out  WIDTH  read data; valid when rd_valid is high.
- rd_valid  out  1  one-cycle pulse, one cycle after rden.
- err  out  1  one-cycle pulse on an illegal access.
- regs_q  out  DEPTH*WIDTH  flattened live register contents for the core.

Behaviour:
- Reset (rst=0, asynchronous):
  - regs_q = RESET_VAL; data_out = 0; rd_valid = 0; err = 0.
  - Takes effect immediately, including mid-access. Any read or write issued in the reset cycle is discarded.
- Write (wren=1 sampled at edge N; update visible on regs_q after edge N):
  - For every byte lane b with sel[b]=1, and every bit j in lane b of register addr:
    - W1C bit: data_in[j]=1 clears the bit; data_in[j]=0 leaves it unchanged.
    - RW bit: takes data_in[j] when lock=0; unchanged when lock=1.
  - Bits in lanes with sel[b]=0 are unchanged. sel=0 is a legal no-op and does not raise err.
  - W1C bits are not affected by lock.
- Hardware set: any W1C bit with hw_set=1 becomes 1 at the next edge. hw_set on RW bits is ignored.
- Simultaneous hw_set and W1C clear on the same bit in the same cycle: the set wins and the bit ends at 1.
- Read (rden=1 at edge N):
  - At edge N+1, data_out = the register value as it was before any write at edge N (read-before-write), and rd_valid=1 for exactly one cycle.
  - data_out holds its value until the next read.
  - Back-to-back reads are supported: one result per cycle.
- Simultaneous rden and wren:
  - Both are performed. The read returns the old value.
  - err is raised if either access is illegal, as defined below.
- Illegal access conditions:
  - addr >= DEPTH. A write is ignored. A read returns 0, with rd_valid still raised.
  - A write while lock=1, with any sel lane containing a RW bit in the addressed register. Only the W1C bits are updated.
  - err pulses high for one cycle, one cycle after the illegal access (aligned with rd_valid).
- Non-power-of-two DEPTH: indices DEPTH..2**ADDR_W-1 are out of range; no storage exists for them.
- No combinational path from inputs to any output; all outputs are registered.

Decomposition:
- Shared package register_rw_pkg:
  - byte-lane count function: WIDTH/8.
  - helper for extracting register i from the flattened vectors.
  - localparam encodings for the err cause, for debug use.
- One sub-module, register_rw_cell:
  - one WIDTH-bit register with sel, lock, W1C mask, hw_set and reset value.
  - instantiated DEPTH times by a generate loop.
- The top level holds address decode, the read mux/register and err generation.

Test Plan (default parameters, plus one run with WIDTH=16, DEPTH=3):
- Reset: rst low then high -> regs_q = RESET_VAL, rd_valid=0, err=0; rden at addr 0 -> data_out=0 with rd_valid one cycle later.
- Byte strobes: write 0xAABBCCDD to addr 1 with sel=4'b0101 -> register 1 = 0x00BB00DD; read returns 0x00BB00DD one cycle after rden.
- Read-before-write: rden and wren to addr 2 together, data 0x12345678 -> data_out = old value 0x0; a following read returns 0x12345678.
- W1C (W1C_MASK bit 0 of register 3 = 1): hw_set pulse -> bit 0 = 1; write 0x1 -> bit 0 = 0; hw_set and write 0x1 in the same cycle -> bit 0 = 1.
- Lock: lock=1, write 0xFFFFFFFF to a RW register -> value unchanged and err pulses once; lock=0 repeat -> value 0xFFFFFFFF and no err.
- Out of range (DEPTH=3): write addr 3 -> no register changes, err=1; read addr 3 -> data_out=0, rd_valid=1, err=1. Assert rst mid-read -> rd_valid stays 0.
